// File: rtl/bus_master_tx.sv
// Serial system-bus master port: requests the bus, serialises select/address/burst
// LSB first, then streams a back-pressured write burst or waits for read completion.
module bus_master_tx #(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 8,
   parameter int BURST_W = 12,
   parameter int SEL_W   = 2,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         instruction,
   input  logic [SEL_W-1:0]   slave_select,
   input  logic [ADDR_W-1:0]  address,
   input  logic [BURST_W-1:0] burst_num,
   input  logic [DATA_W-1:0]  data,
   input  logic               data_valid,
   output logic               data_ready,
   input  logic               approval_grant,
   input  logic               busy,
   input  logic               slave_ready,
   input  logic               rx_done,
   output logic               approval_request,
   output logic               tx_slave_select,
   output logic               tx_address,
   output logic               tx_burst_number,
   output logic               tx_data,
   output logic               master_valid,
   output logic               master_ready,
   output logic               write_en,
   output logic               read_en,
   output logic               tx_done,
   output logic               cmd_busy,
   output logic               err,
   output logic [1:0]         err_code
);

   typedef enum logic [3:0] {
      S_IDLE, S_REQ, S_SEL, S_HWAIT, S_HDR, S_WDATA, S_RWAIT, S_DONE, S_ERR
   } state_t;

   localparam int HDR_W   = (ADDR_W > BURST_W) ? ADDR_W : BURST_W;
   localparam int MAX_W0  = (HDR_W > DATA_W) ? HDR_W : DATA_W;
   localparam int MAX_W   = (MAX_W0 > SEL_W) ? MAX_W0 : SEL_W;
   localparam int CNT_W   = $clog2(MAX_W) + 1;
   localparam int TMO_W   = $clog2(TIMEOUT + 2);
   localparam int TMO_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [TMO_W-1:0]     tmo_q, tmo_d;
   logic [BURST_W-1:0]   words_q, words_d;
   logic                 is_wr_q, is_wr_d;
   logic                 hold_q, hold_d;
   logic [SEL_W-1:0]     sel_q, sel_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [BURST_W-1:0]   burst_q, burst_d;
   logic [DATA_W-1:0]    data_q, data_d;
   logic [1:0]           code_d;
   logic                 tmo_hit, grant_lost;

   assign tmo_hit    = (TIMEOUT != 0) && (tmo_q == TMO_W'(TMO_LIM));
   assign grant_lost = !approval_grant &&
                       (state_q inside {S_SEL, S_HWAIT, S_HDR, S_WDATA, S_RWAIT});

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      words_d = words_q;
      is_wr_d = is_wr_q;
      hold_d  = hold_q;
      sel_d   = sel_q;
      addr_d  = addr_q;
      burst_d = burst_q;
      data_d  = data_q;
      code_d  = err_code;

      if (grant_lost) begin
         state_d = S_ERR;
         code_d  = 2'b10;
      end else begin
         case (state_q)
            S_IDLE: if (start && (instruction == 2'b01 || instruction == 2'b10)) begin
               state_d = S_REQ;
               is_wr_d = (instruction == 2'b01);
               sel_d   = slave_select;
               addr_d  = address;
               burst_d = burst_num;
               words_d = (burst_num == '0) ? BURST_W'(1) : burst_num;
               hold_d  = 1'b0;
               code_d  = 2'b00;
            end
            S_REQ: begin
               if (approval_grant && !busy) state_d = S_SEL;
               else if (tmo_hit) begin
                  state_d = S_ERR;
                  code_d  = 2'b01;
               end else tmo_d = tmo_q + TMO_W'(1);
            end
            S_SEL: begin
               sel_d = sel_q >> 1;
               if (cnt_q == CNT_W'(SEL_W - 1)) state_d = S_HWAIT;
               else cnt_d = cnt_q + CNT_W'(1);
            end
            S_HWAIT: begin
               if (slave_ready) state_d = S_HDR;
               else if (tmo_hit) begin
                  state_d = S_ERR;
                  code_d  = 2'b01;
               end else tmo_d = tmo_q + TMO_W'(1);
            end
            S_HDR: begin
               // Zero shifted in from the top pads whichever field is shorter.
               addr_d  = addr_q >> 1;
               burst_d = burst_q >> 1;
               if (cnt_q == CNT_W'(HDR_W - 1)) state_d = is_wr_q ? S_WDATA : S_RWAIT;
               else cnt_d = cnt_q + CNT_W'(1);
            end
            S_WDATA: begin
               if (hold_q) begin
                  data_d = data_q >> 1;
                  if (cnt_q == CNT_W'(DATA_W - 1)) begin
                     hold_d = 1'b0;
                     cnt_d  = '0;
                     if (words_q == BURST_W'(1)) state_d = S_DONE;
                     else words_d = words_q - BURST_W'(1);
                  end else cnt_d = cnt_q + CNT_W'(1);
               end else if (data_valid) begin
                  data_d = data;
                  hold_d = 1'b1;
                  cnt_d  = '0;
                  tmo_d  = '0;
               end else if (tmo_hit) begin
                  state_d = S_ERR;
                  code_d  = 2'b01;
               end else tmo_d = tmo_q + TMO_W'(1);
            end
            S_RWAIT: begin
               if (rx_done) state_d = S_DONE;
               else if (tmo_hit) begin
                  state_d = S_ERR;
                  code_d  = 2'b01;
               end else tmo_d = tmo_q + TMO_W'(1);
            end
            default: state_d = S_IDLE;
         endcase
      end

      if (state_d != state_q) begin
         cnt_d = '0;
         tmo_d = '0;
      end
   end

   // Outputs are decoded from the next-state values and registered alongside the state.
   logic in_xfer, hdr_nx, wd_nx;
   assign in_xfer = state_d inside {S_SEL, S_HWAIT, S_HDR, S_WDATA, S_RWAIT, S_DONE};
   assign hdr_nx  = (state_d == S_HDR);
   assign wd_nx   = (state_d == S_WDATA);

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (reset) begin
         state_q          <= S_IDLE;
         cnt_q            <= '0;
         tmo_q            <= '0;
         words_q          <= '0;
         is_wr_q          <= 1'b0;
         hold_q           <= 1'b0;
         sel_q            <= '0;
         addr_q           <= '0;
         burst_q          <= '0;
         data_q           <= '0;
         data_ready       <= 1'b0;
         approval_request <= 1'b0;
         tx_slave_select  <= 1'b0;
         tx_address       <= 1'b0;
         tx_burst_number  <= 1'b0;
         tx_data          <= 1'b0;
         master_valid     <= 1'b0;
         master_ready     <= 1'b0;
         write_en         <= 1'b0;
         read_en          <= 1'b0;
         tx_done          <= 1'b0;
         cmd_busy         <= 1'b0;
         err              <= 1'b0;
         err_code         <= 2'b00;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         tmo_q            <= tmo_d;
         words_q          <= words_d;
         is_wr_q          <= is_wr_d;
         hold_q           <= hold_d;
         sel_q            <= sel_d;
         addr_q           <= addr_d;
         burst_q          <= burst_d;
         data_q           <= data_d;
         data_ready       <= wd_nx && !hold_d;
         approval_request <= state_d inside {S_REQ, S_SEL, S_HWAIT, S_HDR, S_WDATA, S_RWAIT};
         tx_slave_select  <= (state_d == S_SEL) && sel_d[0];
         tx_address       <= hdr_nx && addr_d[0];
         tx_burst_number  <= hdr_nx && burst_d[0];
         tx_data          <= wd_nx && hold_d && data_d[0];
         master_valid     <= (state_d == S_SEL) || hdr_nx || (wd_nx && hold_d);
         master_ready     <= (state_d == S_RWAIT);
         write_en         <= in_xfer && is_wr_d;
         read_en          <= in_xfer && !is_wr_d;
         tx_done          <= (state_d == S_DONE);
         cmd_busy         <= (state_d != S_IDLE);
         err              <= (state_d == S_ERR);
         err_code         <= code_d;
      end
   end

endmodule
